// File: rtl/fetch_pkg.sv
// Shared constants and types for the prefetching fetch stage.
// Optional build macro: FETCH_STATS_EN (adds flush/starve statistics counters).
package fetch_pkg;

    // Default geometry of the fetch stage.
    localparam int FETCH_PC_W    = 32;
    localparam int FETCH_IMEM_AW = 12;
    localparam int FETCH_DEPTH   = 4;

    // Jump field is a word target; shift left by this to get a byte target.
    localparam int JUMP_SHIFT = 2;
    // Sequential fetch step in bytes.
    localparam int PC_INCR    = 4;

    // One queued instruction together with its PC+4 (link/branch base).
    typedef struct packed {
        logic [31:0]           instruction;
        logic [FETCH_PC_W-1:0] pc;
    } fetch_entry_t;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO holding fetched {instruction, pc+4} entries.
// Flush beats push and pop; reset clears pointers, count and storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  logic [W-1:0]              wdata_i,
    input  logic                      pop_i,
    output logic [W-1:0]              head_o,
    output logic [count_w(DEPTH)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_w(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;

    logic push_ok;
    logic pop_ok;

    // A pop on an empty queue or a push on a full one is silently ignored.
    assign push_ok = push_i && (count_q != CW'(DEPTH));
    assign pop_ok  = pop_i && (count_q != '0);

    // Next pointer/count values; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (flush_i) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + PW'(1);
            if (pop_ok)  rd_d = rd_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer, count and storage registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            if (push_ok && !flush_i) begin
                mem_q[wr_q] <= wdata_i;
            end
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Prefetching fetch stage: issues one synchronous imem read per cycle into a
// DEPTH-entry queue and hands {instruction, pc+4} to decode over valid/ready.
// Optional build macro: FETCH_STATS_EN adds stat_flush / stat_starve outputs.
//
// Handshake: out_valid is high whenever the queue holds an entry; an entry is
// transferred on any cycle where out_valid and out_ready are both high, except
// during a redirect, where the queue is flushed and the pop is discarded.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int PC_W    = FETCH_PC_W,
    parameter int IMEM_AW = FETCH_IMEM_AW,
    parameter int DEPTH   = FETCH_DEPTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [PC_W-1:0]    jump,
    input  logic               ctrl_jump,
    input  logic [PC_W-1:0]    branchPC,
    input  logic               ctrl_branch,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] insn_address,
    input  logic [31:0]        q_imem,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        instruction,
    output logic [PC_W-1:0]    pc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]        stat_flush,
    output logic [31:0]        stat_starve
`endif
);

    localparam int EW = 32 + PC_W;
    localparam int CW = count_w(DEPTH);

    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;

    logic            redirect;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_plus;
    logic [CW:0]     occupancy;
    logic            issue;
    logic            push;
    logic            pop;
    logic [EW-1:0]   head;
    logic [CW-1:0]   count;

    // Branch wins over jump when both redirect in the same cycle.
    assign redirect = ctrl_branch || ctrl_jump;
    assign target   = ctrl_branch ? branchPC : PC_W'(jump << JUMP_SHIFT);
    assign pc_plus  = fetch_pc_q + PC_W'(PC_INCR);

    // Queued entries plus the outstanding read must leave room for one more;
    // this guarantees the returning data always finds a free slot.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    assign issue     = !reset && !redirect && (occupancy < (CW+1)'(DEPTH));

    // Returning data is squashed on a redirect; reset clears the FIFO anyway.
    assign push = inflight_q && !redirect;
    assign pop  = out_valid && out_ready;

    // Next PC and in-flight tracking.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect) begin
            fetch_pc_d = target;
        end else if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = pc_plus;
            fetch_pc_d    = pc_plus;
        end
    end

    // PC and in-flight registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q    <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush_i (redirect),
        .push_i  (push),
        .wdata_i ({q_imem, inflight_pc_q}),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count)
    );

    assign imem_req     = issue;
    assign insn_address = fetch_pc_q[IMEM_AW+1:2];
    assign out_valid    = !reset && (count != '0);
    assign instruction  = reset ? 32'd0 : head[EW-1:PC_W];
    assign pc           = reset ? '0 : head[PC_W-1:0];

`ifdef FETCH_STATS_EN
    logic [31:0] stat_flush_q;
    logic [31:0] stat_starve_q;

    // Saturating counters of redirect cycles and decode-starved cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_flush_q  <= '0;
            stat_starve_q <= '0;
        end else begin
            if (redirect && (stat_flush_q != '1)) begin
                stat_flush_q <= stat_flush_q + 32'd1;
            end
            if (!out_valid && out_ready && (stat_starve_q != '1)) begin
                stat_starve_q <= stat_starve_q + 32'd1;
            end
        end
    end

    assign stat_flush  = stat_flush_q;
    assign stat_starve = stat_starve_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed cases from cold start, stall,
// redirects and PC wrap, then randomized traffic against a queue-based model.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int PC_W    = 32;
    localparam int IMEM_AW = 12;
    localparam int DEPTH   = 4;

    // Clock / reset and DUT signals
    logic               clock = 1'b0;
    logic               reset;
    logic [PC_W-1:0]    jump;
    logic               ctrl_jump;
    logic [PC_W-1:0]    branchPC;
    logic               ctrl_branch;
    logic               imem_req;
    logic [IMEM_AW-1:0] insn_address;
    logic [31:0]        q_imem = 32'd0;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        instruction;
    logic [PC_W-1:0]    pc;

    always #5 clock = ~clock;

    fetch_queue #(
        .PC_W    (PC_W),
        .IMEM_AW (IMEM_AW),
        .DEPTH   (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .jump         (jump),
        .ctrl_jump    (ctrl_jump),
        .branchPC     (branchPC),
        .ctrl_branch  (ctrl_branch),
        .imem_req     (imem_req),
        .insn_address (insn_address),
        .q_imem       (q_imem),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .instruction  (instruction),
        .pc           (pc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Instruction memory contents: word address a holds a*16+1.
    function automatic logic [31:0] imem_word(input logic [IMEM_AW-1:0] a);
        return 32'(a) * 32'd16 + 32'd1;
    endfunction

    // Synchronous imem: data for the address appears one cycle later.
    always @(posedge clock) q_imem <= imem_word(insn_address);

    // Behavioural model: architectural PC, one outstanding read, queue of entries.
    fetch_entry_t        m_q[$];
    logic [PC_W-1:0]     m_pc = '0;
    bit                  m_inf = 1'b0;
    logic [IMEM_AW-1:0]  m_inf_addr = '0;
    logic [PC_W-1:0]     m_inf_pc = '0;

    function automatic bit model_req();
        return !reset && !(ctrl_branch || ctrl_jump) && ((m_q.size() + int'(m_inf)) < DEPTH);
    endfunction

    function automatic logic [PC_W-1:0] model_head_pc();
        return (m_q.size() != 0) ? m_q[0].pc : '0;
    endfunction

    always @(posedge clock) begin
        bit req;
        fetch_entry_t e;
        req = model_req();
        if (reset) begin
            m_q.delete();
            m_inf = 1'b0;
            m_pc  = '0;
        end else if (ctrl_branch || ctrl_jump) begin
            m_q.delete();
            m_inf = 1'b0;
            m_pc  = ctrl_branch ? branchPC : {jump[PC_W-3:0], 2'b00};
        end else begin
            if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
            if (m_inf) begin
                check("queue_room", 64'(m_q.size() < DEPTH), 64'd1);
                e.instruction = imem_word(m_inf_addr);
                e.pc          = m_inf_pc;
                m_q.push_back(e);
            end
            if (req) begin
                m_inf      = 1'b1;
                m_inf_addr = m_pc[IMEM_AW+1:2];
                m_inf_pc   = m_pc + PC_W'(4);
                m_pc       = m_pc + PC_W'(4);
            end else begin
                m_inf = 1'b0;
            end
        end
    end

    // Compare process: every cycle on the falling edge.
    always @(negedge clock) begin
        bit exp_req;
        bit exp_valid;
        exp_req   = model_req();
        exp_valid = !reset && (m_q.size() != 0);
        check("imem_req", 64'(imem_req), 64'(exp_req));
        if (exp_req) check("insn_address", 64'(insn_address), 64'(m_pc[IMEM_AW+1:2]));
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        if (reset) begin
            check("instruction_rst", 64'(instruction), 64'd0);
            check("pc_rst", 64'(pc), 64'd0);
        end else if (exp_valid) begin
            check("instruction", 64'(instruction), 64'(m_q[0].instruction));
            check("pc", 64'(pc), 64'(m_q[0].pc));
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic redirect(input bit br, input logic [PC_W-1:0] tgt_b, input bit jp, input logic [PC_W-1:0] tgt_j);
        ctrl_branch = br;
        branchPC    = tgt_b;
        ctrl_jump   = jp;
        jump        = tgt_j;
    endtask

    int n_req;

    initial begin
        reset = 1'b1;
        redirect(1'b0, '0, 1'b0, '0);
        out_ready = 1'b0;
        repeat (3) tick();

        // Cold start with decode stalled: exactly DEPTH requests, then throttle.
        reset = 1'b0;
        n_req = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i == 0) check("cold_addr", 64'(insn_address), 64'd0);
            if (i == 2) check("cold_valid_c2", 64'(out_valid), 64'd1);
            if (imem_req) n_req++;
            tick();
        end
        check("stall_req_count", 64'(n_req), 64'd4);
        @(negedge clock);
        check("stall_no_req", 64'(imem_req), 64'd0);
        check("stall_full_valid", 64'(out_valid), 64'd1);
        check("model_head_pc", 64'(model_head_pc()), 64'd4);
        tick();

        // Release: pcs 4, 8, 12, 16, 20 back-to-back.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("rel_valid", 64'(out_valid), 64'd1);
            check("rel_pc", 64'(pc), 64'(4 * (i + 1)));
            check("rel_insn", 64'(instruction), 64'(i * 16 + 1));
            tick();
        end
        repeat (4) tick();

        // Jump to word 0x40.
        redirect(1'b0, '0, 1'b1, 32'h40);
        @(negedge clock);
        check("jmp_no_req", 64'(imem_req), 64'd0);
        tick();
        redirect(1'b0, '0, 1'b0, '0);
        @(negedge clock);
        check("jmp_addr", 64'(insn_address), 64'h40);
        check("jmp_req", 64'(imem_req), 64'd1);
        tick();
        @(negedge clock);
        check("jmp_t2_valid", 64'(out_valid), 64'd0);
        tick();
        @(negedge clock);
        check("jmp_t3_valid", 64'(out_valid), 64'd1);
        check("jmp_pc", 64'(pc), 64'h104);
        check("jmp_insn", 64'(instruction), 64'h401);
        tick();
        repeat (3) tick();

        // Branch and jump together: branch wins.
        redirect(1'b1, 32'h200, 1'b1, 32'h10);
        tick();
        redirect(1'b0, '0, 1'b0, '0);
        @(negedge clock);
        check("br_addr", 64'(insn_address), 64'h80);
        tick();
        tick();
        @(negedge clock);
        check("br_pc", 64'(pc), 64'h204);
        check("br_insn", 64'(instruction), 64'h801);
        tick();

        // Redirect while full and popping.
        out_ready = 1'b0;
        repeat (8) tick();
        out_ready = 1'b1;
        redirect(1'b0, '0, 1'b1, 32'h20);
        @(negedge clock);
        check("full_valid_t", 64'(out_valid), 64'd1);
        check("full_no_req_t", 64'(imem_req), 64'd0);
        tick();
        redirect(1'b0, '0, 1'b0, '0);
        @(negedge clock);
        check("flush_empty_t1", 64'(out_valid), 64'd0);
        tick();
        @(negedge clock);
        check("flush_empty_t2", 64'(out_valid), 64'd0);
        tick();
        @(negedge clock);
        check("flush_valid_t3", 64'(out_valid), 64'd1);
        check("flush_pc_t3", 64'(pc), 64'h84);
        check("flush_insn_t3", 64'(instruction), 64'h201);
        tick();

        // PC wrap from 0xFFFFFFFC.
        redirect(1'b1, 32'hFFFF_FFFC, 1'b0, '0);
        tick();
        redirect(1'b0, '0, 1'b0, '0);
        @(negedge clock);
        check("wrap_addr", 64'(insn_address), 64'hFFF);
        tick();
        tick();
        @(negedge clock);
        check("wrap_pc", 64'(pc), 64'h0);
        check("wrap_insn", 64'(instruction), 64'hFFF1);
        tick();
        @(negedge clock);
        check("wrap_next_pc", 64'(pc), 64'h4);
        check("wrap_next_insn", 64'(instruction), 64'h1);
        tick();

        // Reset mid-stream.
        repeat (3) tick();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("rst_req", 64'(imem_req), 64'd0);
            check("rst_valid", 64'(out_valid), 64'd0);
            check("rst_insn", 64'(instruction), 64'd0);
            check("rst_pc", 64'(pc), 64'd0);
            tick();
        end
        reset = 1'b0;
        @(negedge clock);
        check("rst_cold_req", 64'(imem_req), 64'd1);
        check("rst_cold_addr", 64'(insn_address), 64'd0);
        tick();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            reset     = ($urandom_range(0, 299) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            if (r < 3)      redirect(1'b1, {$urandom(), 2'b00} >> 0 & 32'hFFFF_FFFC, 1'b0, $urandom());
            else if (r < 6) redirect(1'b0, $urandom(), 1'b1, $urandom());
            else if (r < 7) redirect(1'b1, $urandom() & 32'hFFFF_FFFC, 1'b1, $urandom());
            else            redirect(1'b0, '0, 1'b0, '0);
            tick();
        end
        reset = 1'b0;
        redirect(1'b0, '0, 1'b0, '0);
        out_ready = 1'b1;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-register fetch stage.
- Decouples instruction fetch from decode with a DEPTH-entry prefetch queue, so decode stalls no longer freeze the PC.
- Issues one instruction-memory read per cycle against a synchronous imem (data returns one cycle after the address).
- Handles jump/branch redirects by flushing queued and in-flight instructions; delivers {instruction, PC+4} to decode over a valid/ready handshake.

Parameters:
- PC_W, 32, PC and branch-target width in bits.
- IMEM_AW, 12, imem word-address width; insn_address = fetch_pc[IMEM_AW+1:2].
- DEPTH, 4, prefetch queue entries; power of two, >= 2.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- jump  in  PC_W  jump field as a word target; byte target = {jump[PC_W-3:0], 2'b00}.
- ctrl_jump  in  1  redirect to the jump target this cycle.
- branchPC  in  PC_W  branch byte target.
- ctrl_branch  in  1  redirect to branchPC this cycle; has priority over ctrl_jump.
- imem_req  out  1  read strobe for insn_address this cycle.
- insn_address  out  IMEM_AW  imem word address.
- q_imem  in  32  imem read data; valid the cycle after imem_req.
- out_valid  out  1  head queue entry is valid.
- out_ready  in  1  decode accepts the head entry.
- instruction  out  32  head entry instruction.
- pc  out  PC_W  head entry PC+4 (link/branch base, same convention as the previous stage).

Behaviour:
- State:
  - fetch_pc register.
  - inflight flag plus inflight_pc (PC+4 of the outstanding read).
  - Queue: storage, rd/wr pointers, count of 0..DEPTH.
- Reset values: fetch_pc=0, inflight=0, count=0, pointers=0, storage=0.
  - Outputs under reset: imem_req=0, out_valid=0, instruction=0, pc=0.
- Issue rule (cycle without redirect and without reset):
  - imem_req = (count + inflight < DEPTH), where count is the pre-pop value.
  - On issue: inflight<=1, inflight_pc<=fetch_pc+4, fetch_pc<=fetch_pc+4 (mod 2^PC_W, wraps silently).
  - Otherwise: inflight<=0.
- Return:
  - If inflight=1 and the cycle is not a redirect, {q_imem, inflight_pc} is written at the queue tail.
  - The throttle guarantees space, so a push never hits full.
- Pop: out_valid & out_ready advances the head. Push and pop in the same cycle leave count unchanged.
- Output timing:
  - out_valid = (count != 0); instruction/pc come combinationally from the head slot.
  - Contents while empty are don't-care.
- Redirect (ctrl_branch | ctrl_jump) at cycle t:
  - target = ctrl_branch ? branchPC : jump-shifted.
  - fetch_pc<=target; count and pointers cleared; the in-flight read is squashed.
  - No imem_req at t; a pop at t is ignored and decode discards its own copy.
- Redirect latency: request at target issued in t+1, data at t+2, out_valid=1 at t+3.
- Cold start: reset low in cycle 0 → first request at PC 0 in cycle 0, out_valid in cycle 2.
- Steady state with out_ready=1: one instruction per cycle.
- With out_ready=0: queue fills to DEPTH, then imem_req=0 until a pop.
- Reset mid-operation dominates redirect, push and pop; the in-flight read is dropped.

Optional Feature:
- Macro FETCH_STATS_EN.
- When defined, adds outputs stat_flush[31:0] and stat_starve[31:0]; both clear on reset and saturate at all-ones.
  - stat_flush counts redirect cycles.
  - stat_starve counts cycles with out_valid=0 and out_ready=1.
- When undefined: no ports, no counters; behaviour otherwise identical.

Decomposition:
- fetch_pkg holds:
  - default PC_W/IMEM_AW/DEPTH constants.
  - JUMP_SHIFT=2 and PC_INCR=4.
  - fetch_entry_t typedef {instruction[31:0], pc[PC_W-1:0]}.
- One sub-module, fetch_fifo:
  - DEPTH-entry synchronous FIFO with push, pop, flush, count and head outputs.
  - Flush beats push/pop; reset clears it.
- fetch_queue holds the PC, issue throttle, squash and redirect muxing.

Test Plan:
- Cold start, out_ready=1, imem returns word addr*16+1 → out_valid from cycle 2; pc stream 4, 8, 12…; instructions 0x1, 0x11, 0x21….
- out_ready=0 for 10 cycles → exactly DEPTH=4 requests; imem_req=0 afterwards; on release, pc 4, 8, 12, 16 then continuous with no gap or duplicate.
- ctrl_jump with jump=0x40 → flush; next request has insn_address=0x40; first delivered pc=0x104; squashed data never appears.
- ctrl_branch=1 and ctrl_jump=1 together, branchPC=0x200, jump=0x10 → next insn_address=0x80 (branch wins).
- Redirect while full and popping → count=0 next cycle; pop ignored; out_valid returns at t+3.
- fetch_pc=0xFFFFFFFC with PC_W=32 → delivered pc=0x0; fetch continues from 0; reset asserted mid-stream → all outputs 0 next cycle.
